elevator_scheduler: RTL and testbench

Request scheduler and sequencer for a single elevator car.
- Latches floor call buttons into a pending-request register.
- Selects travel direction using SCAN ordering: keep going while any request lies ahead, reverse otherwise.
- Times floor-to-floor travel and door dwell.
- Drives the 2-bit up_down command consumed by the car FSM, and tracks the current floor for the display logic.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_req_ahead.sv | 36 +++
 rtl/elevator_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and encodings for the single-car elevator scheduler.
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   function automatic logic [1:0] dir_cmd(input logic up);
      return up ? DIR_UP : DIR_DOWN;
   endfunction

endpackage

// File: rtl/elevator_req_ahead.sv
// Classifies pending requests relative to a floor: above, below, at it, and
// ahead of the given travel direction.
module elevator_req_ahead #(
   parameter int NUM_FLOORS = 4,
   parameter int FLOOR_W    = 2
) (
   input  logic [NUM_FLOORS-1:0] i_pending,
   input  logic [FLOOR_W-1:0]    i_cur_floor,
   input  logic                  i_dir_up,
   output logic                  o_req_above,
   output logic                  o_req_below,
   output logic                  o_req_here,
   output logic                  o_req_ahead
);

   logic [NUM_FLOORS-1:0] w_above_mask;
   logic [NUM_FLOORS-1:0] w_below_mask;
   logic [NUM_FLOORS-1:0] w_here_mask;

   always_comb begin
      w_above_mask = '0;
      w_below_mask = '0;
      w_here_mask  = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_above_mask[i] = (i > int'(i_cur_floor));
         w_below_mask[i] = (i < int'(i_cur_floor));
         w_here_mask[i]  = (i == int'(i_cur_floor));
      end
   end

   assign o_req_above = |(i_pending & w_above_mask);
   assign o_req_below = |(i_pending & w_below_mask);
   assign o_req_here  = |(i_pending & w_here_mask);
   assign o_req_ahead = i_dir_up ? o_req_above : o_req_below;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-ordered request scheduler for one elevator car: latches calls, times
// floor travel and door dwell, and drives the up/down command.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = 4,
   parameter int FLOOR_W       = 2,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [1:0]            up_down,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TIMER_W = $clog2(TMAX);
   localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [FLOOR_W-1:0] BOT_FLOOR   = '0;

   state_t                r_state;
   logic                  r_dir_up;
   logic [TIMER_W-1:0]    r_timer;
   logic [FLOOR_W-1:0]    r_cur_floor;
   logic [NUM_FLOORS-1:0] r_pending;
   logic [1:0]            r_up_down;
   logic                  r_door_open;
   logic                  r_busy;

   logic [NUM_FLOORS-1:0] w_pend_in;
   logic [NUM_FLOORS-1:0] w_cur_pend;
   logic [NUM_FLOORS-1:0] w_clear_mask;
   logic [FLOOR_W-1:0]    w_next_floor;
   logic                  w_dir_cur;
   logic                  w_dir_next;
   logic                  w_cur_above, w_cur_below, w_cur_here, w_cur_ahead;
   logic                  w_nxt_above, w_nxt_below, w_nxt_here, w_nxt_ahead;
   logic                  w_cur_any, w_nxt_any;
   logic                  w_cur_sel_dir, w_nxt_sel_dir;
   logic                  w_arrive;
   logic                  w_door_restart;

   // Calls seen this cycle take part in arrival and door-expiry decisions;
   // IDLE only acts on latched requests so the latch cycle is always visible.
   assign w_pend_in  = r_pending | call_req;
   assign w_cur_pend = (r_state == ST_IDLE) ? r_pending : w_pend_in;

   assign w_dir_cur = (r_cur_floor == TOP_FLOOR) ? 1'b0 :
                      (r_cur_floor == BOT_FLOOR) ? 1'b1 : r_dir_up;

   always_comb begin
      w_next_floor = r_cur_floor;
      if (r_dir_up && (r_cur_floor != TOP_FLOOR)) begin
         w_next_floor = r_cur_floor + 1'b1;
      end else if (!r_dir_up && (r_cur_floor != BOT_FLOOR)) begin
         w_next_floor = r_cur_floor - 1'b1;
      end
   end

   assign w_dir_next = (w_next_floor == TOP_FLOOR) ? 1'b0 :
                       (w_next_floor == BOT_FLOOR) ? 1'b1 : r_dir_up;

   elevator_req_ahead #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_req_cur (
      .i_pending   (w_cur_pend),
      .i_cur_floor (r_cur_floor),
      .i_dir_up    (w_dir_cur),
      .o_req_above (w_cur_above),
      .o_req_below (w_cur_below),
      .o_req_here  (w_cur_here),
      .o_req_ahead (w_cur_ahead)
   );

   elevator_req_ahead #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_req_next (
      .i_pending   (w_pend_in),
      .i_cur_floor (w_next_floor),
      .i_dir_up    (w_dir_next),
      .o_req_above (w_nxt_above),
      .o_req_below (w_nxt_below),
      .o_req_here  (w_nxt_here),
      .o_req_ahead (w_nxt_ahead)
   );

   assign w_cur_any     = w_cur_above | w_cur_below;
   assign w_nxt_any     = w_nxt_above | w_nxt_below;
   assign w_cur_sel_dir = w_cur_ahead ? w_dir_cur : ~w_dir_cur;
   assign w_nxt_sel_dir = w_nxt_ahead ? w_dir_next : ~w_dir_next;

   assign w_arrive       = (r_state == ST_MOVE) && (r_timer == '0);
   assign w_door_restart = (r_state == ST_DOOR) && call_req[r_cur_floor];

   // While the door is open its own floor bit is held clear, so a repeat
   // press only restarts the dwell.
   always_comb begin
      w_clear_mask = '0;
      case (r_state)
         ST_IDLE: if (w_cur_here) w_clear_mask = NUM_FLOORS'(1) << r_cur_floor;
         ST_MOVE: if (w_arrive && w_nxt_here) w_clear_mask = NUM_FLOORS'(1) << w_next_floor;
         ST_DOOR: w_clear_mask = NUM_FLOORS'(1) << r_cur_floor;
         default: w_clear_mask = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_dir_up    <= 1'b1;
         r_timer     <= '0;
         r_cur_floor <= '0;
         r_pending   <= '0;
         r_up_down   <= DIR_STOP;
         r_door_open <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_pending <= w_pend_in & ~w_clear_mask;
         case (r_state)
            ST_IDLE: begin
               if (w_cur_here) begin
                  r_state     <= ST_DOOR;
                  r_timer     <= DOOR_LOAD;
                  r_door_open <= 1'b1;
                  r_up_down   <= DIR_STOP;
                  r_busy      <= 1'b1;
               end else if (w_cur_any) begin
                  r_state   <= ST_MOVE;
                  r_timer   <= TRAVEL_LOAD;
                  r_dir_up  <= w_cur_sel_dir;
                  r_up_down <= dir_cmd(w_cur_sel_dir);
                  r_busy    <= 1'b1;
               end else begin
                  r_up_down   <= DIR_STOP;
                  r_door_open <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            ST_MOVE: begin
               if (r_timer != '0) begin
                  r_timer <= r_timer - 1'b1;
               end else begin
                  r_cur_floor <= w_next_floor;
                  if (w_nxt_here) begin
                     r_state     <= ST_DOOR;
                     r_timer     <= DOOR_LOAD;
                     r_dir_up    <= w_dir_next;
                     r_door_open <= 1'b1;
                     r_up_down   <= DIR_STOP;
                  end else if (w_nxt_any) begin
                     r_timer   <= TRAVEL_LOAD;
                     r_dir_up  <= w_nxt_sel_dir;
                     r_up_down <= dir_cmd(w_nxt_sel_dir);
                  end else begin
                     r_state   <= ST_IDLE;
                     r_dir_up  <= w_dir_next;
                     r_up_down <= DIR_STOP;
                     r_busy    <= 1'b0;
                  end
               end
            end
            ST_DOOR: begin
               if (w_door_restart) begin
                  r_timer <= DOOR_LOAD;
               end else if (r_timer != '0) begin
                  r_timer <= r_timer - 1'b1;
               end else begin
                  r_door_open <= 1'b0;
                  if (w_cur_any) begin
                     r_state   <= ST_MOVE;
                     r_timer   <= TRAVEL_LOAD;
                     r_dir_up  <= w_cur_sel_dir;
                     r_up_down <= dir_cmd(w_cur_sel_dir);
                  end else begin
                     r_state  <= ST_IDLE;
                     r_dir_up <= w_dir_cur;
                     r_busy   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_up_down   <= DIR_STOP;
               r_door_open <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign up_down   = r_up_down;
   assign cur_floor = r_cur_floor;
   assign door_open = r_door_open;
   assign pending   = r_pending;
   assign busy      = r_busy;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: a table of single-call trips plus
// hand-written SCAN, door-restart, all-buttons and reset sequences.
module tb_elevator_scheduler;
   import elevator_pkg::*;

   localparam int NF = 4;
   localparam int FW = 2;
   localparam int TC = 8;
   localparam int DC = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NF-1:0] call_req = '0;
   logic [1:0]    up_down;
   logic [FW-1:0] cur_floor;
   logic          door_open;
   logic [NF-1:0] pending;
   logic          busy;

   elevator_scheduler #(
      .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .call_req  (call_req),
      .up_down   (up_down),
      .cur_floor (cur_floor),
      .door_open (door_open),
      .pending   (pending),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int         floor;
      logic [1:0] dir;
      int         move_cycles;
   } vec_t;
   vec_t vecs[6];

   int         got_floor_q[$];
   int         got_len_q[$];
   logic [1:0] got_dir_q[$];
   logic [3:0] exp_q[$];
   int         exp_len_q[$];
   logic [1:0] exp_dir_q[$];
   bit         watch_timeout;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      call_req = '0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic press(input logic [NF-1:0] m);
      call_req = m;
      tick();
      call_req = '0;
   endtask

   task automatic wait_floor(input int f);
      int c;
      c = 0;
      while (int'(cur_floor) != f && c < 200) begin
         tick();
         c++;
      end
      if (c >= 200) check("wait floor timeout", int'(cur_floor), f);
   endtask

   // Records door floors, door lengths and every change of up_down until the
   // car has been busy and returned to idle.
   task automatic watch(input int budget);
      logic       prev_door;
      logic [1:0] prev_dir;
      bit         seen_busy;
      bit         done;
      int         len;
      got_floor_q.delete();
      got_len_q.delete();
      got_dir_q.delete();
      prev_door = door_open;
      prev_dir  = up_down;
      seen_busy = busy;
      done = 0;
      len = 0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (up_down != prev_dir) got_dir_q.push_back(up_down);
         prev_dir = up_down;
         if (door_open) begin
            if (!prev_door) begin
               got_floor_q.push_back(int'(cur_floor));
               len = 0;
            end
            len++;
         end else if (prev_door) begin
            got_len_q.push_back(len);
         end
         prev_door = door_open;
         if (busy) seen_busy = 1;
         if (seen_busy && !busy && !door_open) begin
            done = 1;
            break;
         end
      end
      watch_timeout = !done;
      check("watch timeout", int'(watch_timeout), 0);
   endtask

   task automatic compare_watch(input string tag);
      check({tag, " door count"}, got_floor_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_floor_q.size(); i++)
         check($sformatf("%s door floor %0d", tag, i), got_floor_q[i], int'(exp_q[i]));
      check({tag, " dwell count"}, got_len_q.size(), exp_len_q.size());
      for (int i = 0; i < exp_len_q.size() && i < got_len_q.size(); i++)
         check($sformatf("%s dwell %0d", tag, i), got_len_q[i], exp_len_q[i]);
      check({tag, " dir change count"}, got_dir_q.size(), exp_dir_q.size());
      for (int i = 0; i < exp_dir_q.size() && i < got_dir_q.size(); i++)
         check($sformatf("%s dir change %0d", tag, i), int'(got_dir_q[i]), int'(exp_dir_q[i]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int errs;
      int moves;
      int bad;
      int n;
      int c;

      vecs[0] = '{floor: 3, dir: DIR_UP,   move_cycles: 3 * TC};
      vecs[1] = '{floor: 1, dir: DIR_DOWN, move_cycles: 2 * TC};
      vecs[2] = '{floor: 1, dir: DIR_STOP, move_cycles: 0};
      vecs[3] = '{floor: 0, dir: DIR_DOWN, move_cycles: 1 * TC};
      vecs[4] = '{floor: 2, dir: DIR_UP,   move_cycles: 2 * TC};
      vecs[5] = '{floor: 3, dir: DIR_UP,   move_cycles: 1 * TC};

      // reset values while reset is held, then a quiet idle period
      #1;
      check("rst up_down", int'(up_down), 0);
      check("rst cur_floor", int'(cur_floor), 0);
      check("rst door_open", int'(door_open), 0);
      check("rst pending", int'(pending), 0);
      check("rst busy", int'(busy), 0);
      do_reset();
      errs = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (up_down != 2'b00 || cur_floor != '0 || door_open || busy || pending != '0) errs++;
      end
      check("idle 50 cycles errors", errs, 0);

      // single-call trips from wherever the previous trip ended
      for (int v = 0; v < 6; v++) begin
         press(NF'(1) << vecs[v].floor);
         moves = 0;
         bad = 0;
         c = 0;
         while (c < 200) begin
            tick();
            c++;
            if (door_open) break;
            if (up_down == vecs[v].dir) moves++;
            else bad++;
         end
         check($sformatf("vec%0d door reached", v), int'(door_open), 1);
         check($sformatf("vec%0d travel cycles", v), moves, vecs[v].move_cycles);
         check($sformatf("vec%0d wrong dir cycles", v), bad, 0);
         n = 1;
         c = 0;
         while (c < 50) begin
            tick();
            c++;
            if (!door_open) break;
            n++;
         end
         check($sformatf("vec%0d dwell", v), n, DC);
         check($sformatf("vec%0d cur_floor", v), int'(cur_floor), vecs[v].floor);
         check($sformatf("vec%0d pending", v), int'(pending), 0);
         check($sformatf("vec%0d busy", v), int'(busy), 0);
      end

      // same-floor latency and dwell restart
      do_reset();
      press(4'b0001);
      check("latency latch cycle door", int'(door_open), 0);
      tick();
      check("latency state cycle door", int'(door_open), 1);
      tick();
      tick();
      tick();
      call_req = 4'b0001;
      tick();
      call_req = '0;
      check("restart pending stays clear", int'(pending), 0);
      check("restart door still open", int'(door_open), 1);
      n = 1;
      c = 0;
      while (c < 50) begin
         tick();
         c++;
         if (!door_open) break;
         n++;
      end
      check("restart dwell after repeat", n, DC);
      check("restart busy after", int'(busy), 0);

      // SCAN: moving up at floor 2 with calls at 3 and 0
      do_reset();
      press(4'b1000);
      wait_floor(2);
      press(4'b0001);
      check("scan pending", int'(pending), 4'b1001);
      check("scan moving up", int'(up_down), int'(DIR_UP));
      watch(500);
      exp_q = '{4'd3, 4'd0};
      exp_len_q = '{DC, DC};
      exp_dir_q = '{DIR_STOP, DIR_DOWN, DIR_STOP};
      compare_watch("scan");
      check("scan final floor", int'(cur_floor), 0);
      check("scan final pending", int'(pending), 0);

      // all buttons at floor 0: served bottom to top without reversing
      do_reset();
      press(4'b1111);
      watch(800);
      exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
      exp_len_q = '{DC, DC, DC, DC};
      exp_dir_q = '{DIR_UP, DIR_STOP, DIR_UP, DIR_STOP, DIR_UP, DIR_STOP};
      compare_watch("all4");
      check("all4 final floor", int'(cur_floor), 3);
      check("all4 final pending", int'(pending), 0);

      // asynchronous reset in the middle of a move
      do_reset();
      press(4'b1000);
      wait_floor(2);
      tick();
      tick();
      tick();
      check("premid up_down", int'(up_down), int'(DIR_UP));
      check("premid pending", int'(pending), 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst up_down", int'(up_down), 0);
      check("async rst cur_floor", int'(cur_floor), 0);
      check("async rst door_open", int'(door_open), 0);
      check("async rst pending", int'(pending), 0);
      check("async rst busy", int'(busy), 0);
      rst_n = 1'b1;
      tick();
      tick();
      check("post rst busy", int'(busy), 0);
      check("post rst up_down", int'(up_down), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
